// File: rtl/rab_lookup_arb_fsm_pkg.sv
// rab_fsm_pkg: shared state type and sizing helper for the RAB lookup arbiter
package rab_fsm_pkg;

    typedef enum logic {READY = 1'b0, WAIT = 1'b1} state_e;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rab_lookup_arb_fsm_rr.sv
// rab_rr_arbiter: combinational rotate-priority pick starting at the pointer
module rab_rr_arbiter
    import rab_fsm_pkg::*;
#(
    parameter int N_PORTS = 2,
    localparam int SEL_W = sel_w(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [SEL_W-1:0]   grant_o,
    output logic               valid_o
);

    int idx;

    // Scan downward so the lowest rotated offset with a request wins last.
    always_comb begin
        grant_o = ptr_i;
        valid_o = |req_i;
        idx = 0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % N_PORTS;
            if (req_i[idx]) grant_o = SEL_W'(idx);
        end
    end

endmodule

// File: rtl/rab_lookup_arb_fsm.sv
// rab_lookup_arb_fsm: N-port round-robin lookup arbiter with accept/drop handshake and WAIT timeout
module rab_lookup_arb_fsm
    import rab_fsm_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 40,
    parameter int N_PORTS = 2,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SEL_W = sel_w(N_PORTS)
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RI,
    input  logic [N_PORTS-1:0]        AddrValid_DI,
    input  logic [N_PORTS-1:0]        Skip_DI,
    input  logic [N_PORTS-1:0]        Sent_DI,
    output logic [SEL_W-1:0]          Sel_DO,
    input  logic                      NoHit_SI,
    input  logic                      MultiHit_SI,
    input  logic                      NoProt_SI,
    input  logic [AXI_ADDR_WIDTH-1:0] OutAddr_DI,
    input  logic                      CacheCoherent_SI,
    output logic [N_PORTS-1:0]        Accept_SO,
    output logic [N_PORTS-1:0]        Drop_SO,
    output logic [AXI_ADDR_WIDTH-1:0] OutAddr_DO,
    output logic                      CacheCoherent_SO,
    output logic [SEL_W-1:0]          MissPort_DO,
    output logic                      IntMiss_SO,
    output logic                      IntMulti_SO,
    output logic                      IntProt_SO,
    output logic                      IntTimeout_SO,
    output logic                      Busy_SO
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] owner_q, owner_d, ptr_q, ptr_d, grant;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_valid, grant_fire, err, timeout;

    rab_rr_arbiter #(.N_PORTS(N_PORTS)) u_rr (
        .req_i  (AddrValid_DI),
        .ptr_i  (ptr_q),
        .grant_o(grant),
        .valid_o(gnt_valid)
    );

    assign Sel_DO     = grant;
    assign Busy_SO    = state_q == WAIT;
    assign grant_fire = state_q == READY && gnt_valid;
    assign err        = NoHit_SI | MultiHit_SI | ~NoProt_SI | Skip_DI[grant];

    // Control registers: state, owning port, round-robin pointer, WAIT counter.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q <= READY;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: grant in READY, leave WAIT on owner's sent or on timeout (sent wins).
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        if (grant_fire) begin
            state_d = WAIT;
            owner_d = grant;
            ptr_d   = (grant == SEL_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;
            cnt_d   = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
            if (Sent_DI[owner_q]) begin
                state_d = READY;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = READY;
                timeout = 1'b1;
            end
        end
    end

    // Output stage: single-cycle pulses on grant/timeout, address and miss port held.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            Accept_SO        <= '0;
            Drop_SO          <= '0;
            OutAddr_DO       <= '0;
            CacheCoherent_SO <= 1'b0;
            MissPort_DO      <= '0;
            IntMiss_SO       <= 1'b0;
            IntMulti_SO      <= 1'b0;
            IntProt_SO       <= 1'b0;
            IntTimeout_SO    <= 1'b0;
        end else begin
            Accept_SO     <= '0;
            Drop_SO       <= '0;
            IntMiss_SO    <= 1'b0;
            IntMulti_SO   <= 1'b0;
            IntProt_SO    <= 1'b0;
            IntTimeout_SO <= timeout;
            if (grant_fire) begin
                Accept_SO[grant] <= ~err;
                Drop_SO[grant]   <= err;
                OutAddr_DO       <= OutAddr_DI;
                CacheCoherent_SO <= CacheCoherent_SI;
                IntMiss_SO       <= NoHit_SI & ~Skip_DI[grant];
                IntMulti_SO      <= MultiHit_SI & ~Skip_DI[grant];
                IntProt_SO       <= ~NoProt_SI & ~Skip_DI[grant];
                if (err) MissPort_DO <= grant;
            end
        end
    end

endmodule

// File: tb/tb_rab_lookup_arb_fsm.sv
// tb_rab_lookup_arb_fsm: scenario tasks plus randomized traffic against a transaction-level model
module tb_rab_lookup_arb_fsm;

    localparam int N = 4;
    localparam int AW = 40;
    localparam int TO = 5;

    logic          clk = 1'b0, rst = 1'b0;
    logic [N-1:0]  valid = '0, skip = '0, sent = '0;
    logic          nohit = 1'b0, multi = 1'b0, noprot = 1'b1, cc_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [1:0]    sel, miss;
    logic [N-1:0]  acc, drop;
    logic [AW-1:0] addr_o;
    logic          cc_o, im, imu, ip, ito, busy;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    rab_lookup_arb_fsm #(.AXI_ADDR_WIDTH(AW), .N_PORTS(N), .TIMEOUT_CYCLES(TO)) dut (
        .Clk_CI(clk), .Rst_RI(rst), .AddrValid_DI(valid), .Skip_DI(skip), .Sent_DI(sent),
        .Sel_DO(sel), .NoHit_SI(nohit), .MultiHit_SI(multi), .NoProt_SI(noprot),
        .OutAddr_DI(addr_i), .CacheCoherent_SI(cc_i), .Accept_SO(acc), .Drop_SO(drop),
        .OutAddr_DO(addr_o), .CacheCoherent_SO(cc_o), .MissPort_DO(miss),
        .IntMiss_SO(im), .IntMulti_SO(imu), .IntProt_SO(ip), .IntTimeout_SO(ito), .Busy_SO(busy)
    );

    // Reference model: one transaction at a time, counted in waited cycles.
    logic          m_busy;
    int            m_owner, m_ptr, m_wait;
    logic [N-1:0]  e_acc, e_drop;
    logic [AW-1:0] e_addr;
    logic          e_cc, e_im, e_imu, e_ip, e_to;
    logic [1:0]    e_miss;

    function automatic int first_valid(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        logic bad;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
            e_acc = '0; e_drop = '0; e_addr = '0; e_cc = 0; e_miss = '0;
            e_im = 0; e_imu = 0; e_ip = 0; e_to = 0;
        end else begin
            e_acc = '0; e_drop = '0; e_im = 0; e_imu = 0; e_ip = 0; e_to = 0;
            if (!m_busy) begin
                if (valid != '0) begin
                    g = first_valid(valid, m_ptr);
                    bad = nohit | multi | !noprot | skip[g];
                    e_acc[g] = !bad;
                    e_drop[g] = bad;
                    e_addr = addr_i;
                    e_cc = cc_i;
                    e_im = nohit & !skip[g];
                    e_imu = multi & !skip[g];
                    e_ip = !noprot & !skip[g];
                    if (bad) e_miss = 2'(g);
                    m_busy = 1; m_owner = g; m_ptr = (g + 1) % N; m_wait = 0;
                end
            end else begin
                m_wait++;
                if (sent[m_owner]) m_busy = 0;
                else if (m_wait == TO) begin m_busy = 0; e_to = 1; end
            end
        end
    end

    wire [2*N+AW+7:0] dut_v = {acc, drop, addr_o, cc_o, miss, im, imu, ip, ito, busy};
    wire [2*N+AW+7:0] exp_v = {e_acc, e_drop, e_addr, e_cc, e_miss, e_im, e_imu, e_ip, e_to, m_busy};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go_idle();
        valid = '0; skip = '0; nohit = 0; multi = 0; noprot = 1;
        for (int i = 0; i < 20 && m_busy; i++) begin
            sent = N'(1) << m_owner;
            tick();
        end
        sent = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || m_busy) begin
            errors++;
            $display("FAIL go_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        #3;
        checks++;
        if (dut_v !== '0) begin errors++; $display("FAIL reset_outputs got=%h required 0", dut_v); end
        checks++;
        if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d required 0", sel); end
        @(negedge clk);
        rst = 0;
        tick();
        checks++;
        if (dut_v !== '0) begin errors++; $display("FAIL reset_idle got=%h required 0", dut_v); end
    endtask

    task automatic test_fairness();
        valid = '1;
        for (int k = 0; k < 5; k++) begin
            int n = 0;
            while (acc == '0 && n < 10) begin tick(); n++; end
            checks++;
            if (acc !== N'(1) << (k % N)) begin
                errors++;
                $display("FAIL fairness_%0d accept=%b required %b", k, acc, N'(1) << (k % N));
            end
            tick();
            sent = N'(1) << (k % N);
            tick();
            sent = '0;
        end
        checks++;
        if (dut_v !== exp_v) begin errors++; $display("FAIL fairness_model got=%h required %h", dut_v, exp_v); end
        go_idle();
    endtask

    task automatic test_miss();
        valid = 4'b0010; nohit = 1;
        #1;
        checks++;
        if (sel !== 2'd1) begin errors++; $display("FAIL miss_sel got=%0d required 1", sel); end
        tick();
        valid = '0; nohit = 0;
        checks++;
        if ({drop, acc, im, miss} !== {4'b0010, 4'b0000, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL miss drop=%b acc=%b intmiss=%b missport=%0d required 0010 0000 1 1", drop, acc, im, miss);
        end
        checks++;
        if (dut_v !== exp_v) begin errors++; $display("FAIL miss_model got=%h required %h", dut_v, exp_v); end
        tick();
        checks++;
        if ({im, drop, miss} !== {1'b0, 4'b0000, 2'd1}) begin
            errors++;
            $display("FAIL miss_pulse intmiss=%b drop=%b missport=%0d required 0 0000 1", im, drop, miss);
        end
        go_idle();
    endtask

    task automatic test_skip();
        valid = 4'b0100; skip = 4'b0100; noprot = 0;
        tick();
        valid = '0; skip = '0; noprot = 1;
        checks++;
        if ({drop, acc, ip, im, imu} !== {4'b0100, 4'b0000, 3'b000}) begin
            errors++;
            $display("FAIL skip drop=%b acc=%b ints=%b%b%b required 0100 0000 000", drop, acc, ip, im, imu);
        end
        go_idle();
    endtask

    task automatic test_timeout();
        valid = 4'b0001;
        tick();
        valid = '0;
        for (int i = 1; i < TO; i++) begin
            tick();
            checks++;
            if ({busy, ito} !== 2'b10) begin errors++; $display("FAIL timeout_wait_%0d busy/to=%b required 10", i, {busy, ito}); end
        end
        tick();
        checks++;
        if ({busy, ito} !== 2'b01) begin errors++; $display("FAIL timeout_fire busy/to=%b required 01", {busy, ito}); end
        tick();
        checks++;
        if (ito !== 1'b0) begin errors++; $display("FAIL timeout_pulse to=%b required 0", ito); end
        go_idle();
    endtask

    task automatic test_timeout_sent();
        valid = 4'b0001;
        tick();
        valid = '0;
        for (int i = 1; i < TO; i++) tick();
        sent = 4'b0001;
        tick();
        sent = '0;
        checks++;
        if ({busy, ito} !== 2'b00) begin errors++; $display("FAIL timeout_sent busy/to=%b required 00", {busy, ito}); end
        go_idle();
    endtask

    task automatic test_owner_sent();
        valid = 4'b0001;
        tick();
        valid = '0;
        sent = 4'b0100;
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL other_sent busy=%b required 1", busy); end
        sent = 4'b0001;
        tick();
        sent = '0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL owner_sent busy=%b required 0", busy); end
        go_idle();
    endtask

    task automatic test_reset_midwait();
        valid = '1;
        tick();
        checks++;
        if (acc === '0) begin errors++; $display("FAIL midwait_pending accept=%b required nonzero", acc); end
        #1 rst = 1;
        #1;
        checks++;
        if (dut_v !== '0) begin errors++; $display("FAIL midwait_reset got=%h required 0", dut_v); end
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (sel !== 2'd0) begin errors++; $display("FAIL midwait_sel got=%0d required 0", sel); end
        tick();
        checks++;
        if (acc !== 4'b0001) begin errors++; $display("FAIL midwait_regrant accept=%b required 0001", acc); end
        go_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            valid = N'($urandom);
            skip = ($urandom % 4 == 0) ? N'($urandom) : '0;
            sent = (m_busy && $urandom % 3 == 0) ? N'(1) << m_owner : (($urandom % 2 == 1) ? N'($urandom) : '0);
            nohit = ($urandom % 5 == 0);
            multi = ($urandom % 7 == 0);
            noprot = ($urandom % 6 != 0);
            addr_i = AW'({$urandom, $urandom});
            cc_i = 1'($urandom);
            #1;
            checks++;
            if (sel !== 2'(m_busy ? m_ptr : first_valid(valid, m_ptr)) && !m_busy) begin
                errors++;
                $display("FAIL rand_sel_%0d got=%0d required %0d", c, sel, first_valid(valid, m_ptr));
            end
            tick();
            checks++;
            if (dut_v !== exp_v) begin errors++; $display("FAIL rand_%0d got=%h required %h", c, dut_v, exp_v); end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_miss();
        test_skip();
        test_timeout();
        test_timeout_sent();
        test_owner_sent();
        test_reset_midwait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
